// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD responder: opcode masks, blank
// character, DDRAM index helper, FSM states and the decoded instruction class.
package lcd_pkg;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam int         DDRAM_DEPTH = 32;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNCSET = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEARING,
    ST_BUSY
  } lcd_state_t;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPCTL,
    CMD_SHIFT,
    CMD_DDRAM
  } lcd_cmd_t;

  function automatic logic [4:0] ddram_index(input logic line, input logic [3:0] col);
    return {line, col};
  endfunction

  // The highest set bit selects the instruction class.
  function automatic lcd_cmd_t decode_instr(input logic [7:0] op);
    if (|(op & OP_DDRAM))                      return CMD_DDRAM;
    else if (|(op & (OP_CGRAM | OP_FUNCSET)))  return CMD_NOP;
    else if (|(op & OP_SHIFT))                 return CMD_SHIFT;
    else if (|(op & OP_DISPCTL))               return CMD_DISPCTL;
    else if (|(op & OP_ENTRY))                 return CMD_ENTRY;
    else if (|(op & OP_HOME))                  return CMD_HOME;
    else if (|(op & OP_CLEAR))                 return CMD_CLEAR;
    else                                       return CMD_NOP;
  endfunction

endpackage

// File: rtl/lcd_busy_timer.sv
// Loadable down-counter; busy while non-zero, last flags the final busy cycle.
module lcd_busy_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_responder.sv
// HD44780-style bus responder: captures write strobes on the falling edge of en,
// maintains a 2x16 DDRAM image, address counter and display flags.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       rw,
  input  logic [7:0] display,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       overrun,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc
);

  localparam int MAX_CYC = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             en_q;
  logic             cap_rs;
  logic             cap_rw;
  logic [7:0]       cap_data;
  logic             strobe;
  logic             accept;
  logic             is_clear;
  lcd_cmd_t         cmd;
  lcd_state_t       state, state_nxt;
  logic [4:0]       clr_idx;
  logic [4:0]       ac;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_last;
  logic             wr_en;
  logic [4:0]       wr_idx;
  logic [7:0]       wr_data;
  logic [7:0]       ddram [DDRAM_DEPTH];

  assign strobe      = en_q & ~en;
  assign accept      = strobe & ~busy & ~cap_rw;
  assign cmd         = decode_instr(cap_data);
  assign is_clear    = accept & ~cap_rs & (cmd == CMD_CLEAR);
  assign cursor_addr = ac;

  lcd_busy_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .busy     (busy),
    .last     (tmr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Clear writes index 0 in the detection cycle so entry k is blank at t+k+1.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    wr_en     = 1'b0;
    wr_idx    = clr_idx;
    wr_data   = BLANK_CHAR;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          if (is_clear) begin
            tmr_val   = CNT_W'(CLEAR_CYCLES);
            state_nxt = ST_CLEARING;
            wr_en     = 1'b1;
            wr_idx    = '0;
          end else begin
            tmr_val   = CNT_W'(BUSY_CYCLES);
            state_nxt = ST_BUSY;
            if (cap_rs) begin
              wr_en   = 1'b1;
              wr_idx  = ac;
              wr_data = cap_data;
            end
          end
        end
      end
      ST_CLEARING: begin
        wr_en = 1'b1;
        if (clr_idx == 5'd31) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (tmr_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clr_idx <= '0;
    else if (is_clear)
      clr_idx <= 5'd1;
    else if (state == ST_CLEARING)
      clr_idx <= clr_idx + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DDRAM_DEPTH; i++) ddram[i] <= BLANK_CHAR;
    end else if (wr_en) begin
      ddram[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= BLANK_CHAR;
    else     rd_data <= ddram[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      cap_rs     <= 1'b0;
      cap_rw     <= 1'b0;
      cap_data   <= '0;
      overrun    <= 1'b0;
      ac         <= '0;
      entry_inc  <= 1'b1;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
    end else begin
      en_q <= en;
      if (en) {cap_rs, cap_rw, cap_data} <= {rs, rw, display};
      if (strobe && busy) overrun <= 1'b1;
      if (accept) begin
        if (cap_rs) begin
          ac <= entry_inc ? ac + 5'd1 : ac - 5'd1;
        end else begin
          case (cmd)
            CMD_CLEAR: begin
              ac        <= '0;
              entry_inc <= 1'b1;
            end
            CMD_HOME:  ac <= '0;
            CMD_ENTRY: entry_inc <= cap_data[1];
            CMD_DISPCTL: begin
              display_on <= cap_data[2];
              cursor_on  <= cap_data[1];
              blink_on   <= cap_data[0];
            end
            CMD_SHIFT: begin
              if (!cap_data[3]) ac <= cap_data[2] ? ac + 5'd1 : ac - 5'd1;
            end
            CMD_DDRAM: ac <= ddram_index(cap_data[6], cap_data[3:0]);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: a vector table of bus transactions with
// expected screen/flag state, plus hand-written busy, overrun and reset sequences.
module tb_lcd_responder;

  localparam int BUSY_N  = 40;
  localparam int CLEAR_N = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] display = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy, overrun, display_on, cursor_on, blink_on, entry_inc;
  logic [4:0] cursor_addr;

  int n_cmp = 0;
  int n_err = 0;

  lcd_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rs          (rs),
    .rw          (rw),
    .display     (display),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .overrun     (overrun),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .entry_inc   (entry_inc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [4:0] ac;
    logic [3:0] flags;  // {display_on, cursor_on, blink_on, entry_inc}
    logic [4:0] idx;
    logic [7:0] ch;
  } vec_t;

  vec_t vecs[26];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns in the detection cycle (en_q=1, en=0).
  task automatic send(input logic r_s, input logic r_w, input logic [7:0] d);
    step();
    en = 1'b1; rs = r_s; rw = r_w; display = d;
    step();
    en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    step();
    while (busy && n < 3000) begin
      step();
      n++;
    end
    if (busy) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic rd_chk(input string nm, input int idx, input logic [7:0] exp);
    rd_addr = 5'(idx);
    step();
    chk(nm, rd_data, exp);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  k;
    logic saw_busy;

    vecs[0]  = '{0, 8'h01, 5'd0,  4'b0001, 5'd0,  8'h20};
    vecs[1]  = '{0, 8'hC3, 5'd19, 4'b0001, 5'd19, 8'h20};
    vecs[2]  = '{1, 8'h41, 5'd20, 4'b0001, 5'd19, 8'h41};
    vecs[3]  = '{0, 8'h04, 5'd20, 4'b0000, 5'd19, 8'h41};
    vecs[4]  = '{0, 8'h80, 5'd0,  4'b0000, 5'd0,  8'h20};
    vecs[5]  = '{1, 8'h5A, 5'd31, 4'b0000, 5'd0,  8'h5A};
    vecs[6]  = '{0, 8'h06, 5'd31, 4'b0001, 5'd0,  8'h5A};
    vecs[7]  = '{0, 8'h8F, 5'd15, 4'b0001, 5'd15, 8'h20};
    vecs[8]  = '{1, 8'h42, 5'd16, 4'b0001, 5'd15, 8'h42};
    vecs[9]  = '{0, 8'h0E, 5'd16, 4'b1101, 5'd15, 8'h42};
    vecs[10] = '{0, 8'h0D, 5'd16, 4'b1011, 5'd16, 8'h20};
    vecs[11] = '{0, 8'h14, 5'd17, 4'b1011, 5'd16, 8'h20};
    vecs[12] = '{0, 8'h10, 5'd16, 4'b1011, 5'd16, 8'h20};
    vecs[13] = '{0, 8'h18, 5'd16, 4'b1011, 5'd16, 8'h20};
    vecs[14] = '{0, 8'h3F, 5'd16, 4'b1011, 5'd19, 8'h41};
    vecs[15] = '{0, 8'h02, 5'd0,  4'b1011, 5'd0,  8'h5A};
    vecs[16] = '{0, 8'hB7, 5'd7,  4'b1011, 5'd7,  8'h20};
    vecs[17] = '{1, 8'h33, 5'd8,  4'b1011, 5'd7,  8'h33};
    vecs[18] = '{0, 8'h00, 5'd8,  4'b1011, 5'd7,  8'h33};
    vecs[19] = '{1, 8'h44, 5'd9,  4'b1011, 5'd8,  8'h44};
    vecs[20] = '{0, 8'h1F, 5'd9,  4'b1011, 5'd8,  8'h44};
    vecs[21] = '{0, 8'hFF, 5'd31, 4'b1011, 5'd31, 8'h20};
    vecs[22] = '{1, 8'h7E, 5'd0,  4'b1011, 5'd31, 8'h7E};
    vecs[23] = '{0, 8'h08, 5'd0,  4'b0001, 5'd31, 8'h7E};
    vecs[24] = '{0, 8'h05, 5'd0,  4'b0000, 5'd0,  8'h5A};
    vecs[25] = '{0, 8'h07, 5'd0,  4'b0001, 5'd0,  8'h5A};

    // Reset state
    repeat (3) step();
    chk("reset_rd_data", rd_data, 8'h20);
    rst = 1'b0;
    step();
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_cursor", cursor_addr, 0);
    chk("reset_flags", {display_on, cursor_on, blink_on, entry_inc}, 4'b0001);
    rd_chk("reset_ddram17", 17, 8'h20);

    for (int i = 0; i < 26; i++) begin
      send(vecs[i].rs, 1'b0, vecs[i].d);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cursor", i), cursor_addr, vecs[i].ac);
      chk($sformatf("vec%0d_flags", i), {display_on, cursor_on, blink_on, entry_inc}, vecs[i].flags);
      rd_chk($sformatf("vec%0d_ddram", i), vecs[i].idx, vecs[i].ch);
    end

    // Clear with index 7 holding 0x33: timing of the sweep and busy length
    send(0, 0, 8'h04);
    wait_idle("pre_clear");
    rd_addr = 5'd7;
    send(0, 0, 8'h01);
    step();
    k = 1;
    while (busy && k < 200) begin
      if (k == 2) chk("clear_idx7_early", rd_data, 8'h33);
      if (k == 33) begin
        chk("clear_idx7_done", rd_data, 8'h20);
        chk("clear_cursor", cursor_addr, 0);
      end
      step();
      k++;
    end
    chk("clear_busy_len", k - 1, CLEAR_N);
    chk("clear_entry_inc", entry_inc, 1);
    rd_chk("clear_idx31", 31, 8'h20);

    // Strobe detected in the first non-busy cycle is accepted
    send(0, 0, 8'h85);
    repeat (BUSY_N) step();
    chk("edge_busy_last", busy, 1);
    en = 1'b1; rs = 1'b1; rw = 1'b0; display = 8'h11;
    step();
    chk("edge_busy_drop", busy, 0);
    en = 1'b0;
    step();
    chk("edge_accept_busy", busy, 1);
    chk("edge_no_overrun", overrun, 0);
    wait_idle("edge");
    chk("edge_cursor", cursor_addr, 6);
    rd_chk("edge_ddram5", 5, 8'h11);

    // Read strobe is ignored entirely
    send(1, 1, 8'h99);
    step();
    chk("rw_busy", busy, 0);
    chk("rw_overrun", overrun, 0);
    chk("rw_cursor", cursor_addr, 6);

    // en held high produces no transaction
    en = 1'b1; rs = 1'b1; rw = 1'b0; display = 8'h77;
    saw_busy = 1'b0;
    repeat (20) begin
      step();
      if (busy) saw_busy = 1'b1;
    end
    chk("en_held_busy", saw_busy, 0);
    rw = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("en_held_release_busy", busy, 0);
    chk("en_held_cursor", cursor_addr, 6);
    rd_chk("en_held_ddram6", 6, 8'h20);

    // Second strobe 5 cycles into busy is dropped and flagged
    send(1, 0, 8'h22);
    repeat (3) step();
    send(1, 0, 8'h66);
    step();
    chk("ovr_flag", overrun, 1);
    wait_idle("ovr");
    chk("ovr_cursor", cursor_addr, 7);
    chk("ovr_sticky", overrun, 1);
    rd_chk("ovr_ddram6", 6, 8'h22);
    rd_chk("ovr_ddram7", 7, 8'h20);

    // Reset during CLEARING
    send(0, 0, 8'hDE);
    wait_idle("rst_addr");
    send(1, 0, 8'h55);
    wait_idle("rst_data");
    send(0, 0, 8'h0F);
    wait_idle("rst_disp");
    rd_chk("rst_pre_ddram30", 30, 8'h55);
    send(0, 0, 8'h01);
    repeat (10) step();
    chk("rst_mid_clear_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cursor", cursor_addr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_flags", {display_on, cursor_on, blink_on, entry_inc}, 4'b0001);
    rd_addr = 5'd30;
    step();
    rst = 1'b0;
    step();
    chk("rst_ddram30", rd_data, 8'h20);
    step();
    chk("rst_stays_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-style responder for the 8-bit parallel LCD bus (`en`, `rs`, `rw`, `display[7:0]`) driven by the game's LCD writer. It latches each bus transaction on the falling edge of `en`, decodes instructions and character data, and maintains a 2x16 DDRAM image, address counter and display-control flags. Pong logic, debug readout and the verification bench read the screen contents back through a registered read port. It also replaces the physical LCD in simulation.

## Interface
Parameters:
- `BUSY_CYCLES`, 40: busy duration after any accepted non-clear transaction.
- `CLEAR_CYCLES`, 1640: busy duration after Clear Display; must be >= 32.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: bus strobe, same clock domain as `clk`.
- `rs` in 1: 0 = instruction, 1 = data.
- `rw` in 1: 0 = write. Transactions with 1 are ignored.
- `display` in 8: bus data.
- `rd_addr` in 5: DDRAM read index, `{line, col[3:0]}`.
- `rd_data` out 8: registered DDRAM content at `rd_addr`.
- `busy` out 1: responder is not accepting transactions.
- `overrun` out 1: sticky; a transaction arrived while `busy`.
- `cursor_addr` out 5: address counter (AC), `{line, col}`.
- `display_on`, `cursor_on`, `blink_on` out 1 each: display-control flags.
- `entry_inc` out 1: 1 = AC increments, 0 = AC decrements.

## Operation
- Falling-edge detection: `en_q` is `en` registered. A strobe is detected when `en_q`=1 and `en`=0. `rs`, `rw` and `display` are sampled from the last cycle in which `en` was 1, held in a capture register that loads whenever `en`=1.
- Acceptance rules:
  - A strobe with `busy`=1 is dropped and sets `overrun`.
  - A strobe with `rw`=1 is dropped without setting `overrun`, and does not start busy.
- Data write (`rs`=1):
  - `ddram[AC] <= display`.
  - AC then moves ±1 modulo 32 according to `entry_inc`. Index 15 → 16 crosses to line 1, and 31 → 0 wraps.
- Instructions (`rs`=0), decoded on the highest set bit:
  - `0x01` Clear: fill all 32 entries with 0x20, one per busy cycle starting at index 0; AC=0; `entry_inc`=1.
  - `0x02`–`0x03` Return home: AC=0.
  - `0x04`–`0x07` Entry mode: `entry_inc`=bit1. The shift bit is ignored.
  - `0x08`–`0x0F` Display control: `display_on`=bit2, `cursor_on`=bit1, `blink_on`=bit0.
  - `0x10`–`0x1F` Shift: if bit3=0, AC moves +1 when bit2=1 and −1 otherwise (mod 32). If bit3=1 (display shift), there is no state change.
  - `0x20`–`0x7F` Function set / CGRAM address: no state change; busy still applies.
  - `0x80`–`0xFF` Set DDRAM address: AC = `{display[6], display[3:0]}`. Bits 5:4 are ignored.
  - `0x00`: no state change; busy still applies.
- Reset values:
  - DDRAM all 0x20.
  - AC=0, `entry_inc`=1.
  - `display_on`, `cursor_on`, `blink_on`, `busy`, `overrun` all 0.
  - `rd_data`=0x20.
  - `en_q`=0 and capture register 0.
- State machine:
  - IDLE: accepted strobe → BUSY (load `BUSY_CYCLES`), or → CLEARING for Clear (load `CLEAR_CYCLES`).
  - CLEARING: writes one blank per cycle; after index 31 → BUSY with the remaining count.
  - BUSY: counter reaches 1 → IDLE.

## Timing
- Detection cycle t: the state update (DDRAM/AC/flags) is visible at t+1. `busy` is high from t+1 through t+N, where N = `BUSY_CYCLES` or `CLEAR_CYCLES`, and is low at t+N+1.
- A strobe detected in the cycle `busy` first drops to 0 is accepted.
- Clear: entries 0..31 become 0x20 at cycles t+1..t+32. AC=0 from t+1.
- `rd_data` has 1-cycle latency from `rd_addr`. A read of the address written at cycle t+1 returns the new value at t+2.
- An `en` pulse of 1 cycle is sufficient. `en` held high indefinitely produces no transaction.
- Reset mid-operation (including CLEARING) aborts immediately to reset values.

## Structure
- `lcd_pkg` contains:
  - opcode masks (CLEAR, HOME, ENTRY, DISPCTL, SHIFT, FUNCSET, CGRAM, DDRAM);
  - `BLANK_CHAR` = 8'h20;
  - the `{line,col}` address-index function;
  - the state enum IDLE/CLEARING/BUSY.
- One sub-module, `lcd_busy_timer`: loadable down-counter with a `busy` output, shared by both busy paths.

## Test plan
- Reset, then Clear, wait out busy, then write 0x41 after Set Address 0xC3 → `rd_addr` 19 reads 0x41, `cursor_addr`=20.
- Entry 0x04 (decrement), Set Address 0x80, write 0x5A → index 0 = 0x5A, `cursor_addr`=31 (wrap).
- Write at AC=15 with increment → `cursor_addr`=16. Command 0x0E → `display_on`=1, `cursor_on`=1, `blink_on`=0.
- Two strobes 5 cycles apart with `BUSY_CYCLES`=40 → second dropped, `overrun`=1, DDRAM unchanged by the second.
- Fill index 7 with 0x33, then Clear → index 7 reads 0x20 by t+33, `busy` high exactly `CLEAR_CYCLES` cycles.
- Assert `rst` during CLEARING at count 10 → `busy`=0, all entries 0x20, AC=0 immediately.
